// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared timing definitions for the raster timing generator.
//   vga_axis_t       : one axis of a video mode (visible, front porch, sync,
//                      back porch), all in pixels (horizontal) or lines
//                      (vertical).
//   VGA_640x480_H/V  : 640x480@60 industry timing (the generator's default).
//   VGA_800x600_H/V  : 800x600@72 timing.
//   axis_total()     : total length of an axis (sum of its four segments).
// -----------------------------------------------------------------------------
package vga_pkg;

   typedef struct packed {
      int unsigned disp;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } vga_axis_t;

   localparam vga_axis_t VGA_640x480_H = '{disp: 640, fp: 16, sync: 96,  bp: 48};
   localparam vga_axis_t VGA_640x480_V = '{disp: 480, fp: 10, sync: 2,   bp: 33};
   localparam vga_axis_t VGA_800x600_H = '{disp: 800, fp: 56, sync: 120, bp: 64};
   localparam vga_axis_t VGA_800x600_V = '{disp: 600, fp: 37, sync: 6,   bp: 23};

   function automatic int unsigned axis_total(input vga_axis_t a);
      return a.disp + a.fp + a.sync + a.bp;
   endfunction

endpackage

// File: rtl/vga_pix_ce_div.sv
// -----------------------------------------------------------------------------
// vga_pix_ce_div
// Pixel clock-enable divider. A counter runs 0..CLK_DIV-1 while enabled and
// pix_ce_o is a registered one-Clk pulse once per CLK_DIV cycles. The first
// pulse after enable (or reset release) appears CLK_DIV Clk edges later.
// With CLK_DIV = 1 the enable is held high while en_i is high.
//   Clk      in  : system clock
//   Reset_n  in  : asynchronous active-low reset
//   en_i     in  : run enable; low clears the counter synchronously
//   pix_ce_o out : registered pixel clock-enable pulse
// -----------------------------------------------------------------------------
module vga_pix_ce_div #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic en_i,
   output logic pix_ce_o
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pix_ce_q, pix_ce_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the block can leave a value unassigned and infer a latch.
      cnt_d    = '0;
      pix_ce_d = 1'b0;
      if (en_i) begin
         pix_ce_d = (cnt_q == CNT_LAST);
         cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its inputs from before the edge, independent of statement order.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q    <= '0;
         pix_ce_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         pix_ce_q <= pix_ce_d;
      end
   end

   assign pix_ce_o = pix_ce_q;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised raster timing generator running on the system clock with a
// pixel clock-enable. Horizontal/vertical counters advance once per pix_ce;
// hs, vs, blank and the event strobes are registered from the next counter
// values so they change on the same Clk edge as DrawX/DrawY.
// Optional feature (macro VGA_FRAME_CNT_EN): 16-bit frame counter and field bit.
//   Clk          in  : system clock
//   Reset_n      in  : asynchronous active-low reset
//   en           in  : run enable; low restarts everything synchronously
//   pix_ce       out : one-Clk pulse per pixel period
//   DrawX/DrawY  out : pixel / line counters
//   hs, vs       out : syncs, at HS_POL/VS_POL while asserted
//   blank        out : 1 inside the visible window
//   sync         out : composite sync, tied 0
//   line_start   out : DrawX just became 0
//   frame_start  out : (DrawX,DrawY) just became (0,0)
//   vblank_start out : DrawY just became V_DISP at DrawX 0 (buffer swap point)
//   frame_cnt    out : frames started since restart (VGA_FRAME_CNT_EN only)
//   field        out : frame_cnt[0] (VGA_FRAME_CNT_EN only)
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned COORD_W = 10,
   parameter int unsigned H_DISP  = VGA_640x480_H.disp,
   parameter int unsigned H_FP    = VGA_640x480_H.fp,
   parameter int unsigned H_SYNC  = VGA_640x480_H.sync,
   parameter int unsigned H_BP    = VGA_640x480_H.bp,
   parameter int unsigned V_DISP  = VGA_640x480_V.disp,
   parameter int unsigned V_FP    = VGA_640x480_V.fp,
   parameter int unsigned V_SYNC  = VGA_640x480_V.sync,
   parameter int unsigned V_BP    = VGA_640x480_V.bp,
   parameter bit          HS_POL  = 1'b0,
   parameter bit          VS_POL  = 1'b0
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               en,
   output logic               pix_ce,
   output logic [COORD_W-1:0] DrawX,
   output logic [COORD_W-1:0] DrawY,
   output logic               hs,
   output logic               vs,
   output logic               blank,
   output logic               sync,
   output logic               line_start,
   output logic               frame_start,
`ifdef VGA_FRAME_CNT_EN
   output logic [15:0]        frame_cnt,
   output logic               field,
`endif
   output logic               vblank_start
);

   localparam vga_axis_t H_TIMING = '{disp: H_DISP, fp: H_FP, sync: H_SYNC, bp: H_BP};
   localparam vga_axis_t V_TIMING = '{disp: V_DISP, fp: V_FP, sync: V_SYNC, bp: V_BP};
   localparam int unsigned H_TOTAL = axis_total(H_TIMING);
   localparam int unsigned V_TOTAL = axis_total(V_TIMING);

   // Comparisons run one bit wider than the counters so that a total equal to
   // 2^COORD_W still has representable limits.
   localparam int unsigned CW = COORD_W + 1;
   localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS_END  = CW'(H_DISP);
   localparam logic [CW-1:0] V_VIS_END  = CW'(V_DISP);
   localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_DISP + H_FP);
   localparam logic [CW-1:0] H_SYNC_END = CW'(H_DISP + H_FP + H_SYNC);
   localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_DISP + V_FP);
   localparam logic [CW-1:0] V_SYNC_END = CW'(V_DISP + V_FP + V_SYNC);

   logic               pix_ce_w;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [CW-1:0]      x_ext_q, y_ext_q, x_ext_d, y_ext_d;
   logic               hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;
   logic               vblank_start_q, vblank_start_d;
   logic               advance;

   vga_pix_ce_div #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_ce_div (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .en_i     (en),
      .pix_ce_o (pix_ce_w)
   );

   assign advance = en & pix_ce_w;
   assign x_ext_q = {1'b0, x_q};
   assign y_ext_q = {1'b0, y_q};
   assign x_ext_d = {1'b0, x_d};
   assign y_ext_d = {1'b0, y_d};

   // Counter next state; en low forces the restart position.
   always_comb begin
      x_d = '0;
      y_d = '0;
      if (en) begin
         x_d = x_q;
         y_d = y_q;
         if (advance) begin
            if (x_ext_q == H_LAST) begin
               x_d = '0;
               y_d = (y_ext_q == V_LAST) ? '0 : y_q + COORD_W'(1);
            end else begin
               x_d = x_q + COORD_W'(1);
            end
         end
      end
   end

   // Syncs, blank and strobes derived from the next counter values so they
   // land together with DrawX/DrawY.
   always_comb begin
      hs_d           = ~HS_POL;
      vs_d           = ~VS_POL;
      blank_d        = 1'b0;
      line_start_d   = 1'b0;
      frame_start_d  = 1'b0;
      vblank_start_d = 1'b0;
      if (en) begin
         if (x_ext_d >= H_SYNC_BEG && x_ext_d < H_SYNC_END) hs_d = HS_POL;
         if (y_ext_d >= V_SYNC_BEG && y_ext_d < V_SYNC_END) vs_d = VS_POL;
         blank_d = (x_ext_d < H_VIS_END) && (y_ext_d < V_VIS_END);
         // Strobes need an actual counter step, so the held (0,0) after a
         // restart never produces a frame_start.
         line_start_d   = advance && (x_d == '0);
         frame_start_d  = line_start_d && (y_d == '0);
         vblank_start_d = line_start_d && (y_ext_d == V_VIS_END);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         x_q            <= '0;
         y_q            <= '0;
         hs_q           <= ~HS_POL;
         vs_q           <= ~VS_POL;
         blank_q        <= 1'b0;
         line_start_q   <= 1'b0;
         frame_start_q  <= 1'b0;
         vblank_start_q <= 1'b0;
      end else begin
         x_q            <= x_d;
         y_q            <= y_d;
         hs_q           <= hs_d;
         vs_q           <= vs_d;
         blank_q        <= blank_d;
         line_start_q   <= line_start_d;
         frame_start_q  <= frame_start_d;
         vblank_start_q <= vblank_start_d;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Counts on the same edge that raises frame_start; wraps naturally at 16 bits.
   always_comb begin
      frame_cnt_d = '0;
      if (en) begin
         frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign field     = frame_cnt_q[0];
`endif

   assign pix_ce       = pix_ce_w;
   assign DrawX        = x_q;
   assign DrawY        = y_q;
   assign hs           = hs_q;
   assign vs           = vs_q;
   assign blank        = blank_q;
   assign sync         = 1'b0;
   assign line_start   = line_start_q;
   assign frame_start  = frame_start_q;
   assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Main DUT: reduced timing (32 x 19 total, COORD_W = 5 so H_TOTAL = 2^COORD_W),
// CLK_DIV = 2, active-low syncs, checked cycle by cycle against a pixel-index
// model through an expected-value queue. Second DUT: 800x600 set with
// CLK_DIV = 1 and HS_POL = 1, checked over its first line.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int CD  = 2;
   localparam int HD  = 20, HF = 3, HSY = 4, HB = 5;
   localparam int VD  = 12, VF = 2, VSY = 2, VB = 3;
   localparam int HT  = HD + HF + HSY + HB;   // 32
   localparam int VT  = VD + VF + VSY + VB;   // 19
   localparam int FT  = HT * VT;              // 608 pixels per frame

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       en = 1'b0;

   logic       pix_ce, hs, vs, blank, sync, line_start, frame_start, vblank_start;
   logic [4:0] DrawX, DrawY;
   logic        pce2, hs2, vs2, blank2, sync2, ls2, fs2, vbs2;
   logic [10:0] x2, y2;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt, frame_cnt2;
   logic        field, field2;
`endif

   always #5 Clk = ~Clk;

   vga_timing_gen #(
      .CLK_DIV (CD), .COORD_W (5),
      .H_DISP (HD), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
      .V_DISP (VD), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
      .HS_POL (1'b0), .VS_POL (1'b0)
   ) dut (
      .Clk (Clk), .Reset_n (Reset_n), .en (en),
      .pix_ce (pix_ce), .DrawX (DrawX), .DrawY (DrawY),
      .hs (hs), .vs (vs), .blank (blank), .sync (sync),
      .line_start (line_start), .frame_start (frame_start),
`ifdef VGA_FRAME_CNT_EN
      .frame_cnt (frame_cnt), .field (field),
`endif
      .vblank_start (vblank_start)
   );

   vga_timing_gen #(
      .CLK_DIV (1), .COORD_W (11),
      .H_DISP (800), .H_FP (56), .H_SYNC (120), .H_BP (64),
      .V_DISP (600), .V_FP (37), .V_SYNC (6), .V_BP (23),
      .HS_POL (1'b1), .VS_POL (1'b0)
   ) dut_svga (
      .Clk (Clk), .Reset_n (Reset_n), .en (en),
      .pix_ce (pce2), .DrawX (x2), .DrawY (y2),
      .hs (hs2), .vs (vs2), .blank (blank2), .sync (sync2),
      .line_start (ls2), .frame_start (fs2),
`ifdef VGA_FRAME_CNT_EN
      .frame_cnt (frame_cnt2), .field (field2),
`endif
      .vblank_start (vbs2)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------ model
   typedef struct {
      logic pce;
      int   x, y;
      logic hs, vs, blank, ls, fs, vbs;
      int   fcnt;
   } exp_t;

   exp_t exp_q[$];

   // The model tracks a linear pixel index p and derives (x,y) from it.
   initial begin : model
      int   m_div, m_p, m_fcnt;
      bit   m_pce, adv;
      exp_t e;
      m_div = 0; m_p = 0; m_fcnt = 0; m_pce = 0;
      forever begin
         @(posedge Clk or negedge Reset_n);
         if (!Reset_n || !en) begin
            m_div = 0; m_p = 0; m_pce = 0; m_fcnt = 0;
            e = '{pce: 1'b0, x: 0, y: 0, hs: 1'b1, vs: 1'b1, blank: 1'b0,
                  ls: 1'b0, fs: 1'b0, vbs: 1'b0, fcnt: 0};
         end else begin
            adv = m_pce;
            if (adv) m_p = (m_p + 1) % FT;
            m_pce = (m_div == CD - 1);
            m_div = (m_div + 1) % CD;
            e.pce   = m_pce;
            e.x     = m_p % HT;
            e.y     = m_p / HT;
            e.hs    = !(e.x >= HD + HF && e.x < HD + HF + HSY);
            e.vs    = !(e.y >= VD + VF && e.y < VD + VF + VSY);
            e.blank = (e.x < HD) && (e.y < VD);
            e.ls    = adv && (e.x == 0);
            e.fs    = adv && (m_p == 0);
            e.vbs   = adv && (m_p == VD * HT);
            if (e.fs) m_fcnt = (m_fcnt + 1) & 16'hFFFF;
            e.fcnt  = m_fcnt;
         end
         if (!Reset_n) exp_q.delete();
         exp_q.push_back(e);
      end
   end

   // ------------------------------------------------------- output sampler
   bit period_armed = 0;
   int pce_count = 0;
   int fs_seen = 0;
   bit svga_chk = 0;
   int svga_prev_x = -1;

   initial begin : sampler
      exp_t e;
      forever begin
         @(negedge Clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pix_ce",       32'(pix_ce),       32'(e.pce));
            check("DrawX",        32'(DrawX),        32'(e.x));
            check("DrawY",        32'(DrawY),        32'(e.y));
            check("hs",           32'(hs),           32'(e.hs));
            check("vs",           32'(vs),           32'(e.vs));
            check("blank",        32'(blank),        32'(e.blank));
            check("sync",         32'(sync),         32'd0);
            check("line_start",   32'(line_start),   32'(e.ls));
            check("frame_start",  32'(frame_start),  32'(e.fs));
            check("vblank_start", 32'(vblank_start), 32'(e.vbs));
`ifdef VGA_FRAME_CNT_EN
            check("frame_cnt",    32'(frame_cnt),    32'(e.fcnt));
            check("field",        32'(field),        32'(e.fcnt % 2));
`endif
         end

         // Boundary points, independent of the model.
         if (DrawX == 5'(HD - 1) && DrawY == 5'(VD - 1)) check("blank_last_vis", 32'(blank), 32'd1);
         if (DrawX == 5'(HD) && DrawY == 5'd0)          check("blank_x_edge", 32'(blank), 32'd0);
         if (DrawX == 5'd0 && DrawY == 5'(VD))          check("blank_y_edge", 32'(blank), 32'd0);
         if (DrawX == 5'(HD + HF - 1))       check("hs_before", 32'(hs), 32'd1);
         if (DrawX == 5'(HD + HF))           check("hs_first",  32'(hs), 32'd0);
         if (DrawX == 5'(HD + HF + HSY - 1)) check("hs_last",   32'(hs), 32'd0);
         if (DrawX == 5'(HD + HF + HSY))     check("hs_after",  32'(hs), 32'd1);
         if (DrawY == 5'(VD + VF - 1))       check("vs_before", 32'(vs), 32'd1);
         if (DrawY == 5'(VD + VF))           check("vs_first",  32'(vs), 32'd0);
         if (DrawY == 5'(VD + VF + VSY))     check("vs_after",  32'(vs), 32'd1);
         if (vblank_start) check("vblank_pos", {DrawX, DrawY}, {5'd0, 5'(VD)});
         if (frame_start)  check("fs_with_ls", 32'(line_start), 32'd1);

         // Pixel periods between consecutive frame starts.
         if (frame_start) begin
            fs_seen++;
            if (period_armed) check("frame_period", 32'(pce_count), 32'(FT));
            period_armed = 1;
            pce_count = pix_ce ? 1 : 0;
`ifdef VGA_FRAME_CNT_EN
            if (fs_seen == 3) begin
               check("frame_cnt_3", 32'(frame_cnt), 32'd3);
               check("field_3",     32'(field),     32'd1);
            end
`endif
         end else if (pix_ce) begin
            pce_count++;
         end

         // 800x600, CLK_DIV=1, positive hs over its first line.
         if (svga_chk) begin
            check("svga_pix_ce", 32'(pce2), 32'd1);
            check("svga_hs", 32'(hs2), 32'(x2 >= 11'd856 && x2 < 11'd976));
            if (svga_prev_x >= 0) check("svga_x_step", 32'(x2), 32'((svga_prev_x + 1) % 1040));
            svga_prev_x = int'(x2);
         end
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic first_pce_latency(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!pix_ce && n < 10);
      check(tag, 32'(n), 32'(CD));
   endtask

   initial begin : stim
      int n;
      en = 1'b1;
      repeat (5) @(negedge Clk);
      check("reset_drawx", 32'(DrawX), 32'd0);
      check("reset_hs",    32'(hs),    32'd1);
      check("reset_pce",   32'(pix_ce), 32'd0);
      Reset_n = 1'b1;
      first_pce_latency("first_pce_after_reset");

      // 800x600 checks over a bit more than one line, while the main run continues.
      svga_chk = 1;
      repeat (1100) @(negedge Clk);
      svga_chk = 0;
      repeat (3 * FT * CD) @(negedge Clk);

      // Drop en mid-frame at (15,7).
      n = 0;
      while (!(DrawX == 5'd15 && DrawY == 5'd7) && n < 2 * FT * CD) begin
         @(negedge Clk);
         n++;
      end
      check("reach_15_7", 32'(n < 2 * FT * CD), 32'd1);
      en = 1'b0;
      period_armed = 0;
      @(negedge Clk);
      check("en_low_x",     32'(DrawX),  32'd0);
      check("en_low_y",     32'(DrawY),  32'd0);
      check("en_low_hs",    32'(hs),     32'd1);
      check("en_low_vs",    32'(vs),     32'd1);
      check("en_low_blank", 32'(blank),  32'd0);
      check("en_low_pce",   32'(pix_ce), 32'd0);
      repeat (3) @(negedge Clk);
      en = 1'b1;
      first_pce_latency("first_pce_after_en");
      repeat (300) @(negedge Clk);

      // Asynchronous reset between edges.
      #2 Reset_n = 1'b0;
      period_armed = 0;
      #1;
      check("arst_x",     32'(DrawX),        32'd0);
      check("arst_y",     32'(DrawY),        32'd0);
      check("arst_pce",   32'(pix_ce),       32'd0);
      check("arst_hs",    32'(hs),           32'd1);
      check("arst_vs",    32'(vs),           32'd1);
      check("arst_blank", 32'(blank),        32'd0);
      check("arst_strb",  {line_start, frame_start, vblank_start}, 32'd0);
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      first_pce_latency("first_pce_after_arst");
      repeat (FT * CD + 200) @(negedge Clk);

      check("frames_seen", 32'(fs_seen >= 4), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator; next generation of the lab VGA controller.
- Single-clock design: emits a pixel clock-enable instead of a divided clock.
- Adds configurable timing, sync polarity, enable/restart and frame/line event strobes.
- Sits between the system clock domain and the DAC/pixel pipeline; drives the sprite/colour mapper coordinates.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1; 1 means pix_ce is held high).
- COORD_W, 10, width of DrawX/DrawY; requires 2^COORD_W >= H_TOTAL and >= V_TOTAL.
- H_DISP, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_DISP, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- HS_POL, 0, asserted level of hs.
- VS_POL, 0, asserted level of vs.
- Derived values: H_TOTAL = sum of the four H_* parameters; V_TOTAL likewise.

Ports:
- Clk, input, 1, system clock (50 MHz nominal).
- Reset_n, input, 1, asynchronous active-low reset.
- en, input, 1, run enable; low performs a synchronous restart.
- pix_ce, output, 1, one-Clk pulse per pixel period.
- DrawX, output, COORD_W, horizontal counter, 0..H_TOTAL-1.
- DrawY, output, COORD_W, vertical counter, 0..V_TOTAL-1.
- hs, output, 1, horizontal sync at HS_POL when asserted.
- vs, output, 1, vertical sync at VS_POL when asserted.
- blank, output, 1, 1 = visible region, 0 = blanking (DAC convention).
- sync, output, 1, composite sync; tied 0.
- line_start, output, 1, 1-Clk pulse when DrawX becomes 0.
- frame_start, output, 1, 1-Clk pulse when (DrawX,DrawY) becomes (0,0).
- vblank_start, output, 1, 1-Clk pulse when DrawY becomes V_DISP with DrawX=0; used for buffer swap.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - DrawX = 0, DrawY = 0, pix_ce = 0.
  - hs = ~HS_POL, vs = ~VS_POL.
  - blank = 0.
  - line_start, frame_start and vblank_start = 0.
  - Divider count = 0.
- Divider: counts 0..CLK_DIV-1 and wraps. pix_ce is registered and high in the Clk where count == CLK_DIV-1.
- Counter advance: only in Clk cycles with pix_ce=1.
  - DrawX == H_TOTAL-1: DrawX <= 0. DrawY then wraps to 0 if DrawY == V_TOTAL-1, otherwise increments.
  - Otherwise: DrawX increments.
- hs/vs/blank are registered from the next counter values, so they are aligned with DrawX/DrawY on the same Clk edge (no skew).
  - hs asserted iff H_DISP+H_FP <= DrawX < H_DISP+H_FP+H_SYNC.
  - vs asserted iff V_DISP+V_FP <= DrawY < V_DISP+V_FP+V_SYNC.
  - blank = 1 iff DrawX < H_DISP and DrawY < V_DISP.
- Strobes: registered, asserted for exactly the one Clk in which the qualifying counter update lands.
  - frame_start implies line_start in the same cycle.
  - vblank_start never coincides with frame_start.
- en low, synchronous, overrides everything:
  - Divider, DrawX and DrawY forced to 0.
  - pix_ce = 0; hs/vs deasserted; blank = 0; strobes = 0.
- en rising: first pix_ce occurs CLK_DIV Clk cycles later.
  - DrawX and DrawY hold at 0 until that pix_ce.
  - No frame_start is issued for the initial (0,0); the first frame_start comes after a full frame.
- Reset_n asserted mid-frame: all state returns to reset values immediately. Deassertion behaves as an en rising edge.
- Arithmetic: comparisons are unsigned at COORD_W+1 bits so that H_TOTAL equal to 2^COORD_W is legal.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - Extra output frame_cnt [15:0], reset 0, cleared when en is low.
  - Increments on each frame_start and wraps 0xFFFF -> 0.
  - Extra output field, equal to frame_cnt[0]; used for flicker/double-buffer selection.
- Undefined: neither port exists and no counter logic is synthesised.

Decomposition:
- Shared package vga_pkg:
  - Default timing constants: VGA_640x480 set plus an 800x600@72 set (H 800/56/120/64, V 600/37/6/23).
  - Typedef of a timing struct (disp, fp, sync, bp) for both axes.
  - Function returning total from the struct.
- One natural sub-module: vga_pix_ce_div, the divider producing pix_ce from CLK_DIV.

Test Plan:
- Defaults, en=1 after reset:
  - pix_ce every 2nd Clk.
  - DrawX wraps 799->0 with DrawY incrementing.
  - DrawY wraps 524->0.
  - 420000 pix_ce per frame.
- hs low exactly for DrawX 656..751.
- vs low exactly for DrawY 490..491.
- blank=1 only in the 640x480 window; checked at corners (639,479)=1, (640,0)=0, (0,480)=0.
- Strobes:
  - frame_start at (0,0) once per 420000 pix_ce, coincident with line_start.
  - vblank_start at (0,480).
- en dropped at (300,200):
  - Next Clk: DrawX=DrawY=0, hs=vs=1, blank=0.
  - After re-enable, first pix_ce arrives 2 Clk later.
- Reset_n pulsed low mid-line asynchronously (between Clk edges): outputs reach reset values before the next edge.
- CLK_DIV=1, HS_POL=1, 800x600 set:
  - pix_ce constant high.
  - hs high for DrawX 856..975.
  - With VGA_FRAME_CNT_EN defined: frame_cnt=3 after 3 full frames and field=1.
